// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and widths for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_DIV_W  = 16;

  // Serializer frame phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_sync_fifo.sv
// Single-clock byte FIFO with an explicit occupancy counter.
// The read port is fall-through: rdata always shows the head entry.
// Pushes are refused while full, even if a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [PW:0] LVL_ONE  = (PW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: byte FIFO in front of a START/DATA/STOP serializer.
// Handshake: a byte is transferred on every rising edge where in_valid and
// in_ready are both high; in_ready depends only on FIFO fullness and never
// on in_valid.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [UART_DATA_W-1:0]  in_data,
  input  logic [UART_DIV_W-1:0]   div,
  input  logic                    tx_enable,
  output logic                    ser_tx,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  // Value of the stop counter on the final stop bit.
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e             state, state_next;
  logic [UART_DIV_W-1:0]   bit_cnt, bit_cnt_next;
  logic [UART_DIV_W-1:0]   div_q, div_q_next;
  logic [2:0]              bit_idx, bit_idx_next;
  logic                    stop_cnt, stop_cnt_next;
  logic [UART_DATA_W-1:0]  shreg, shreg_next;
  logic                    ser_next;

  logic                    start_frame;
  logic                    period_end;
  logic [UART_DATA_W-1:0]  head_data;
  logic                    fifo_full;
  logic                    fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (start_frame),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign in_ready   = !fifo_full;
  assign busy       = (state != ST_IDLE);
  assign period_end = (bit_cnt == div_q);

  // Next-state and datapath update; a frame start (from IDLE or straight
  // out of the last stop bit) pops the head and latches the divider.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    div_q_next    = div_q;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    shreg_next    = shreg;
    ser_next      = ser_tx;
    start_frame   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (period_end) begin
          bit_cnt_next = '0;
          state_next   = ST_DATA;
          ser_next     = shreg[0];
        end else begin
          bit_cnt_next = bit_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          bit_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next    = ST_STOP;
            stop_cnt_next = 1'b0;
            ser_next      = 1'b1;
          end else begin
            shreg_next   = shreg >> 1;
            bit_idx_next = bit_idx + 3'd1;
            ser_next     = shreg[1];
          end
        end else begin
          bit_cnt_next = bit_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (period_end) begin
          bit_cnt_next = '0;
          if (stop_cnt == STOP_LAST) begin
            if (tx_enable && !fifo_empty) start_frame = 1'b1;
            else                          state_next  = ST_IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (start_frame) begin
      state_next    = ST_START;
      shreg_next    = head_data;
      div_q_next    = div;
      bit_cnt_next  = '0;
      bit_idx_next  = '0;
      stop_cnt_next = 1'b0;
      ser_next      = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      ser_tx   <= 1'b1;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      div_q    <= div_q_next;
      bit_idx  <= bit_idx_next;
      stop_cnt <= stop_cnt_next;
      shreg    <= shreg_next;
      ser_tx   <= ser_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer (DEPTH=16, STOP_BITS=1).
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] div;
  logic        tx_enable;
  logic        ser_tx;
  logic        busy;
  logic [4:0]  level;

  int checks   = 0;
  int failures = 0;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DEPTH     (16),
    .STOP_BITS (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .div       (div),
    .tx_enable (tx_enable),
    .ser_tx    (ser_tx),
    .busy      (busy),
    .level     (level)
  );

  // Advance one rising edge, then settle 1 ns before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Checks a full 10-bit frame, starting at the sample where the start bit
  // is already on the line; ends on the sample after the last stop clock.
  task automatic expect_frame(input logic [7:0] d, input int dv, input string tag);
    logic [9:0] fr;
    int         b;
    fr = {1'b1, d, 1'b0};
    for (int k = 0; k < 10 * (dv + 1); k++) begin
      b = k / (dv + 1);
      chk($sformatf("%s_line_bit%0d_clk%0d", tag, b, k), {31'd0, ser_tx}, {31'd0, fr[b]});
      chk($sformatf("%s_busy_clk%0d", tag, k), {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    div       = 16'd3;
    tx_enable = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_ser_tx",   {31'd0, ser_tx},   32'd1);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_level",    {27'd0, level},    32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Single byte 0x55 at div=3: 40 busy clocks starting one edge after accept
    tx_enable = 1'b1;
    div       = 16'd3;
    push(8'h55);
    chk("single_level_after_accept", {27'd0, level}, 32'd1);
    chk("single_busy_after_accept",  {31'd0, busy},  32'd0);
    chk("single_line_after_accept",  {31'd0, ser_tx}, 32'd1);
    tick();
    chk("single_level_after_pop", {27'd0, level}, 32'd0);
    expect_frame(8'h55, 3, "single");
    chk("single_busy_end", {31'd0, busy},   32'd0);
    chk("single_line_end", {31'd0, ser_tx}, 32'd1);

    // FIFO full with transmit disabled: 16 accepted, 17th refused
    do_reset();
    tx_enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("full_in_ready_%0d", i), {31'd0, in_ready}, (i < 16) ? 32'd1 : 32'd0);
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      chk($sformatf("full_level_%0d", i), {27'd0, level}, (i + 1 > 16) ? 32'd16 : 32'(i + 1));
      chk($sformatf("full_line_%0d", i), {31'd0, ser_tx}, 32'd1);
    end
    in_valid = 1'b0;
    chk("full_in_ready_final", {31'd0, in_ready}, 32'd0);
    chk("full_busy",           {31'd0, busy},     32'd0);

    // Full with a simultaneous pop: push still refused, level drops by one
    div       = 16'd0;
    tx_enable = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    tick();
    in_valid = 1'b0;
    chk("full_pop_level", {27'd0, level}, 32'd15);
    expect_frame(8'h00, 0, "drain0");
    chk("drain_level", {27'd0, level}, 32'd14);
    tx_enable = 1'b0;
    expect_frame(8'h01, 0, "drain1");
    chk("drain_idle_busy",  {31'd0, busy},   32'd0);
    chk("drain_idle_level", {27'd0, level},  32'd14);
    chk("drain_idle_line",  {31'd0, ser_tx}, 32'd1);

    // Back-to-back 0x41, 0x42 at div=0: 20 contiguous line clocks
    do_reset();
    div       = 16'd0;
    tx_enable = 1'b1;
    push(8'h41);
    push(8'h42);
    chk("b2b_level_first", {27'd0, level}, 32'd1);
    expect_frame(8'h41, 0, "b2b_a");
    chk("b2b_level_second", {27'd0, level}, 32'd0);
    expect_frame(8'h42, 0, "b2b_b");
    chk("b2b_busy_end",  {31'd0, busy},   32'd0);
    chk("b2b_line_end",  {31'd0, ser_tx}, 32'd1);
    chk("b2b_level_end", {27'd0, level},  32'd0);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    do_reset();
    div       = 16'd3;
    tx_enable = 1'b1;
    push(8'hA5);
    push(8'hB1);
    push(8'hC2);
    chk("midrst_level_before", {27'd0, level}, 32'd2);
    repeat (16) tick();
    chk("midrst_line_bit3", {31'd0, ser_tx}, 32'd0);
    chk("midrst_busy_bit3", {31'd0, busy},   32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_line",     {31'd0, ser_tx},   32'd1);
    chk("midrst_busy",     {31'd0, busy},     32'd0);
    chk("midrst_level",    {27'd0, level},    32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("midrst_quiet_line_%0d", i), {31'd0, ser_tx}, 32'd1);
      chk($sformatf("midrst_quiet_busy_%0d", i), {31'd0, busy},   32'd0);
    end

    // Mid-frame disable and divider change; re-enable picks up new divider
    do_reset();
    div       = 16'd3;
    tx_enable = 1'b1;
    push(8'h3C);
    push(8'h5A);
    tx_enable = 1'b0;
    div       = 16'd7;
    expect_frame(8'h3C, 3, "en_div_a");
    chk("en_div_idle_busy",  {31'd0, busy},   32'd0);
    chk("en_div_idle_level", {27'd0, level},  32'd1);
    chk("en_div_idle_line",  {31'd0, ser_tx}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en_div_hold_busy_%0d", i), {31'd0, busy},   32'd0);
      chk($sformatf("en_div_hold_line_%0d", i), {31'd0, ser_tx}, 32'd1);
    end
    tx_enable = 1'b1;
    tick();
    expect_frame(8'h5A, 7, "en_div_b");
    chk("en_div_end_busy",  {31'd0, busy},  32'd0);
    chk("en_div_end_level", {27'd0, level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Synthesizable 8N1 UART transmitter with an input byte FIFO and a valid/ready handshake. It sits directly upstream of the serial display monitor and drives the `ser_tx` line that the monitor samples as its `ser_rx`. Firmware-side logic pushes ASCII bytes into it, and the block serializes them LSB-first at a runtime-programmable bit period.

## Interface
- `DEPTH`, default 16: FIFO depth in bytes; must be a power of two, ≥2.
- `STOP_BITS`, default 1: number of stop bits per frame; legal values are 1 or 2.
- `clk` input, 1 bit: single clock for the whole block.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `in_valid` input, 1 bit: `in_data` is presented.
- `in_ready` output, 1 bit: equals `!full`.
- `in_data` input, 8 bits: byte to transmit.
- `div` input, 16 bits: bit period is `div+1` clocks.
- `tx_enable` input, 1 bit: permits starting new frames.
- `ser_tx` output, 1 bit: serial line; idles high.
- `busy` output, 1 bit: a frame is in progress.
- `level` output, `$clog2(DEPTH)+1` bits: current FIFO occupancy.

## Operation
- **Push:** a byte is accepted on each edge where `in_valid && in_ready`.
  - When full, `in_ready` is 0 and a push is refused, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle (not full) leave `level` unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when `tx_enable && level!=0`. On that edge, pop the FIFO head into the 8-bit shift register, latch `div` into `div_q`, clear the bit counter, and drive `ser_tx=0`.
  - START → DATA after `div_q+1` clocks. `ser_tx` = shift register bit 0.
  - DATA shifts right every `div_q+1` clocks. After 8 bits, go to STOP with `ser_tx=1`.
  - STOP lasts `STOP_BITS*(div_q+1)` clocks. At its end:
    - if `tx_enable && level!=0`, go straight to START (pop and latch as above), with no idle gap;
    - otherwise go to IDLE.
- `busy` = (state != IDLE).
- `div` is sampled only at frame start; changing it mid-frame does not affect the current frame.
- Deasserting `tx_enable` mid-frame lets the current frame complete; no new frame starts.
- **Counters:**
  - bit-period counter: 16 bits, counts 0..`div_q`, wraps to 0;
  - bit index: 3 bits for DATA, 0..7;
  - a separate 1-bit stop counter.
  - `div=0` gives a 1-clock bit period.
- **FIFO pointers:** `$clog2(DEPTH)` bits each, wrapping modulo DEPTH. `level` is tracked explicitly.
- **Reset** (at any time, including mid-frame):
  - state=IDLE, FIFO emptied, `level=0`;
  - `ser_tx=1`, `busy=0`, `in_ready=1`.
  - A partially sent frame is abandoned. The line goes high on the first clock edge with `rst` high.

## Timing
- All outputs are registered except `in_ready` (combinational from `level`).
- **Reset values:** `ser_tx=1`, `busy=0`, `level=0`, `in_ready=1`.
- **Latency:** for a byte accepted on edge N into an empty FIFO with the FSM in IDLE and `tx_enable=1`:
  - `level=1` after N;
  - the pop occurs on edge N+1, where `ser_tx` falls and `busy` rises.
- **Frame length:** `(10 + STOP_BITS - 1) * (div+1)` clocks.
  - Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit clock.
- **Line transitions:** `ser_tx` changes only at bit boundaries or on reset; it never glitches.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/START/DATA/STOP);
  - `UART_DATA_W=8`, `UART_DIV_W=16`.
- One sub-module, `sync_fifo` (parameters DEPTH and WIDTH=8; ports push/pop/full/empty/level). The serializer FSM lives in the top module.

## Test plan
- **Single byte:** reset, `div=3`, push 0x55. Expect:
  - `ser_tx` low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high;
  - `busy` high for exactly 40 clocks, starting 1 clock after the accept edge.
- **FIFO full:** `tx_enable=0`, `DEPTH=16`, push 17 bytes. Expect `in_ready=0` after the 16th accept, `level=16`, the 17th byte not accepted, and `ser_tx` held high throughout.
- **Back-to-back:** push 0x41, 0x42 with `div=0`, `STOP_BITS=1`. Expect 20 contiguous line clocks with no idle cycle between the stop of 0x41 and the start of 0x42, and `level` returning to 0.
- **Reset mid-frame:** assert `rst` during bit 3 of 0xA5 with 2 bytes still queued. Expect on the next edge `ser_tx=1`, `busy=0`, `level=0`, and no further frames after reset is released.
- **Enable and div timing:** drop `tx_enable` and change `div` from 3 to 7 mid-frame. Expect the current frame to finish at 4 clocks per bit and no new frame to start. On re-enable, expect the next frame at 8 clocks per bit.
- **End to end:** with a 10 ns `clk` and `div=2649` (26.5 µs per bit), send "Hi\n" into the serial display monitor. Expect it to print `output: Hi`.
